// File: rtl/gnrc_stream_xbar.sv
// Packet-aware N_IN x N_OUT stream crossbar: per-output arbiters, per-input
// route/drop tracking, a packet lock per output and an optional output register slice.
module gnrc_stream_xbar #(
    parameter int unsigned N_IN     = 2,
    parameter int unsigned N_OUT    = 2,
    parameter int unsigned DW       = 32,
    parameter int unsigned ARB_MODE = 1,
    parameter int unsigned OBUF     = 1,
    parameter int unsigned DEST_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    parameter int unsigned ID_W     = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [N_IN*DW-1:0]     data_i,
    input  logic [N_IN-1:0]        valid_i,
    input  logic [N_IN-1:0]        last_i,
    input  logic [N_IN*DEST_W-1:0] dest_i,
    output logic [N_IN-1:0]        ready_o,
    output logic [N_OUT*DW-1:0]    data_o,
    output logic [N_OUT-1:0]       valid_o,
    output logic [N_OUT-1:0]       last_o,
    output logic [N_OUT*ID_W-1:0]  id_o,
    input  logic [N_OUT-1:0]       ready_i,
    output logic [N_IN-1:0]        drop_o
);

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_ROUTED,
        IN_DROP
    } in_state_e;

    in_state_e        in_state_q [N_IN];
    in_state_e        in_state_d [N_IN];
    logic [N_IN-1:0]  oor;
    logic [N_IN-1:0]  req [N_OUT];

    logic [N_OUT-1:0] out_lock_q;
    logic [ID_W-1:0]  out_owner_q [N_OUT];
    logic [ID_W-1:0]  rr_ptr_q [N_OUT];

    logic [ID_W-1:0]  sel [N_OUT];
    logic [DW-1:0]    beat_data [N_OUT];
    logic [N_OUT-1:0] path_act;
    logic [N_OUT-1:0] beat_valid;
    logic [N_OUT-1:0] beat_last;
    logic [N_OUT-1:0] slice_rdy;
    logic [N_OUT-1:0] xfer;

    // Only idle inputs request; routed inputs are carried by their output's lock.
    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            oor[i] = 32'(dest_i[i*DEST_W +: DEST_W]) >= N_OUT;
        end
        for (int unsigned j = 0; j < N_OUT; j++) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                req[j][i] = valid_i[i] && (in_state_q[i] == IN_IDLE)
                            && (32'(dest_i[i*DEST_W +: DEST_W]) == j);
            end
        end
    end

    always_comb begin
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            sel[j]      = '0;
            path_act[j] = 1'b0;
            if (out_lock_q[j]) begin
                sel[j]      = out_owner_q[j];
                path_act[j] = 1'b1;
            end else begin
                for (int unsigned k = 0; k < N_IN; k++) begin
                    if (ARB_MODE == 1) begin
                        idx = ID_W'((32'(rr_ptr_q[j]) + k) % N_IN);
                    end else begin
                        idx = ID_W'(k);
                    end
                    if (!path_act[j] && req[j][idx]) begin
                        sel[j]      = idx;
                        path_act[j] = 1'b1;
                    end
                end
            end
            beat_valid[j] = path_act[j] && valid_i[sel[j]] && !flush_i;
            beat_last[j]  = last_i[sel[j]];
            beat_data[j]  = data_i[32'(sel[j])*DW +: DW];
            xfer[j]       = beat_valid[j] && slice_rdy[j];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                in_state_q[i] <= IN_IDLE;
            end
        end else begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                in_state_q[i] <= in_state_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            in_state_d[i] = in_state_q[i];
            if (flush_i) begin
                in_state_d[i] = IN_IDLE;
            end else if (valid_i[i] && ready_o[i]) begin
                case (in_state_q[i])
                    IN_IDLE: begin
                        if (!last_i[i]) begin
                            in_state_d[i] = oor[i] ? IN_DROP : IN_ROUTED;
                        end
                    end
                    default: begin
                        if (last_i[i]) begin
                            in_state_d[i] = IN_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            ready_o[i] = 1'b0;
            drop_o[i]  = 1'b0;
            if (!flush_i) begin
                if ((in_state_q[i] == IN_DROP) || ((in_state_q[i] == IN_IDLE) && oor[i])) begin
                    ready_o[i] = 1'b1;
                    drop_o[i]  = valid_i[i];
                end else begin
                    for (int unsigned j = 0; j < N_OUT; j++) begin
                        if (path_act[j] && (32'(sel[j]) == i) && slice_rdy[j]) begin
                            ready_o[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Every accepted last beat advances the pointer, so single-beat packets rotate too.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_lock_q <= '0;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                out_owner_q[j] <= '0;
                rr_ptr_q[j]    <= '0;
            end
        end else if (flush_i) begin
            out_lock_q <= '0;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                out_owner_q[j] <= '0;
                rr_ptr_q[j]    <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < N_OUT; j++) begin
                if (xfer[j]) begin
                    if (beat_last[j]) begin
                        out_lock_q[j] <= 1'b0;
                        if (ARB_MODE == 1) begin
                            rr_ptr_q[j] <= (32'(sel[j]) == N_IN - 1) ? '0 : sel[j] + 1'b1;
                        end
                    end else begin
                        out_lock_q[j]  <= 1'b1;
                        out_owner_q[j] <= sel[j];
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        if (OBUF != 0) begin : g_slice
            logic            v_q;
            logic            l_q;
            logic [DW-1:0]   d_q;
            logic [ID_W-1:0] id_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    v_q  <= 1'b0;
                    l_q  <= 1'b0;
                    d_q  <= '0;
                    id_q <= '0;
                end else if (flush_i) begin
                    v_q  <= 1'b0;
                    l_q  <= 1'b0;
                    d_q  <= '0;
                    id_q <= '0;
                end else if (slice_rdy[j]) begin
                    v_q <= xfer[j];
                    if (xfer[j]) begin
                        l_q  <= beat_last[j];
                        d_q  <= beat_data[j];
                        id_q <= sel[j];
                    end
                end
            end

            assign slice_rdy[j]             = !v_q || ready_i[j];
            assign valid_o[j]               = v_q;
            assign last_o[j]                = l_q;
            assign data_o[j*DW +: DW]       = d_q;
            assign id_o[j*ID_W +: ID_W]     = id_q;
        end else begin : g_comb
            assign slice_rdy[j]             = ready_i[j];
            assign valid_o[j]               = beat_valid[j];
            assign last_o[j]                = beat_valid[j] && beat_last[j];
            assign data_o[j*DW +: DW]       = beat_valid[j] ? beat_data[j] : '0;
            assign id_o[j*ID_W +: ID_W]     = beat_valid[j] ? sel[j] : '0;
        end
    end

endmodule
